// File: rtl/ex_mul_pkg.sv
// Shared types and constants for the EX-stage shift-and-add multiplier.
package ex_mul_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam logic [3:0] ALU_CTRL_MUL = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_unit.sv
// Iterative shift-and-add multiplier for the EX stage; stalls the front of the pipe while busy.
// Optional MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module ex_mul_unit
    import ex_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_sum;
    logic [CW-1:0]    cnt_q;
    logic             start, last, zero_skip;

    assign start   = valid_i && (alu_ctrl_i == ALU_CTRL_MUL) && (state_q == IDLE);
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = (cnt_q == CW'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
    assign zero_skip = (mplier_q == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Reset gating keeps stall low even if a mul is presented while reset is held.
    assign stall_o = rst_i && (start || (state_q == RUN));
    assign done_o  = (state_q == DONE);
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (zero_skip || last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_o <= '0;
        end else begin
            state_q <= state_d;
            if (!flush_i) begin
                if (start) begin
                    mcand_q  <= src1_i;
                    mplier_q <= src2_i;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else if (state_q == RUN) begin
                    if (zero_skip) begin
                        result_o <= acc_q;
                    end else begin
                        acc_q    <= acc_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        if (last) result_o <= acc_sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: vector table plus flush, reset and illegal-code sequences.
module tb_ex_mul_unit;
    import ex_mul_pkg::*;

    localparam int W = 32;

`ifdef MUL_EARLY_TERM_EN
    localparam logic [W-1:0] LONG_B = 32'h8000_0006;
`else
    localparam logic [W-1:0] LONG_B = 32'd6;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   alu = 4'd0;
    logic [W-1:0] s1 = '0;
    logic [W-1:0] s2 = '0;
    logic         stall, done;
    logic [W-1:0] result;
    logic [1:0]   state;

    int checks = 0;
    int failures = 0;
    vec_t vecs[10];

    ex_mul_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .alu_ctrl_i(alu),
        .src1_i(s1), .src2_i(s2), .flush_i(flush),
        .stall_o(stall), .done_o(done), .result_o(result), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_done(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int bl = 0;
        for (int i = 0; i < W; i++) if (b[i]) bl = i + 1;
        return ((bl + 1 < W) ? bl + 1 : W) + 1;
`else
        return W + 1;
`endif
    endfunction

    // Start in cycle 0, keep valid high until DONE has been seen, then confirm IDLE.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
        int cyc, done_cyc;
        bit stall_ok;
        logic [W-1:0] got;
        string tag;
        tag = $sformatf("%h*%h", a, b);
        got = 'x;
        @(posedge clk); #1;
        valid = 1'b1; alu = ALU_CTRL_MUL; s1 = a; s2 = b;
        @(negedge clk);
        check({tag, " stall_c0"}, W'(stall), W'(1));
        stall_ok = 1'b1; cyc = 0; done_cyc = -1;
        while (cyc < W + 10 && done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                got = result;
                if (stall) stall_ok = 1'b0;
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
        end
        check({tag, " done_cycle"}, W'(done_cyc), W'(exp_done(b)));
        check({tag, " result"}, got, p);
        check({tag, " stall_run"}, W'(stall_ok), W'(1));
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check({tag, " back_idle"}, {W'(state), W'(done), W'(stall)} == '0 ? W'(1) : W'(0), W'(1));
        check({tag, " result_hold"}, result, p);
    endtask

    initial begin
        int seen, bad;
        vecs[0] = '{32'd7,          32'd6,          32'd42};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
        vecs[4] = '{32'd12345,      32'd0,          32'd0};
        vecs[5] = '{32'd9,          32'd1,          32'd9};
        vecs[6] = '{32'h8000_0000,  32'd3,          32'h8000_0000};
        vecs[7] = '{32'h0000_1234,  32'h0000_0100,  32'h0012_3400};
        vecs[8] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001};
        vecs[9] = '{32'd7,          32'd6,          32'd42};

        // Reset held with a mul presented: everything must stay quiet.
        valid = 1'b1; alu = ALU_CTRL_MUL; s1 = 32'd3; s2 = 32'd3;
        #12;
        check("rst_state", W'(state), W'(IDLE));
        check("rst_stall", W'(stall), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;

        // Non-mul ALU code never starts the multiplier.
        @(posedge clk); #1;
        valid = 1'b1; alu = 4'b0010; s1 = 32'd7; s2 = 32'd6;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (stall || done || state != IDLE) bad++;
            @(posedge clk); #1;
        end
        check("other_code_idle", W'(bad), W'(0));
        valid = 1'b0; alu = ALU_CTRL_MUL;

        foreach (vecs[i]) run_mul(vecs[i].a, vecs[i].b, vecs[i].p);

        // Flush in cycle 10 after a prior 42: no done, result untouched.
        @(posedge clk); #1;
        valid = 1'b1; alu = ALU_CTRL_MUL; s1 = 32'd5; s2 = LONG_B;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_c10_stall", W'(stall), W'(1));
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("flush_c11_state", W'(state), W'(IDLE));
        check("flush_c11_stall", W'(stall), W'(0));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush_no_done", W'(seen), W'(0));
        check("flush_result", result, 32'd42);

        // Reset in cycle 5 of RUN: outputs zero at once, no late done.
        @(posedge clk); #1;
        valid = 1'b1; alu = ALU_CTRL_MUL; s1 = 32'd3; s2 = LONG_B;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_run_state", W'(state), W'(IDLE));
        check("rst_run_stall", W'(stall), W'(0));
        check("rst_run_done", W'(done), W'(0));
        check("rst_run_result", result, '0);
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rst_run_no_done", W'(seen), W'(0));

        run_mul(32'd11, 32'd13, 32'd143);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1: EX stage holds a valid instruction.
REQ-005 SHALL have port alu_ctrl_i, input, 4: ALU control code from the ALU control stage; 4'b0011 = mul.
REQ-006 SHALL have ports src1_i and src2_i, input, WIDTH: multiplicand and multiplier.
REQ-007 SHALL have port flush_i, input, 1: abort the in-flight multiply.
REQ-008 SHALL have port stall_o, output, 1: hold PC, IF/ID and ID/EX.
REQ-009 SHALL have port done_o, output, 1: one-cycle pulse, result_o valid.
REQ-010 SHALL have port result_o, output, WIDTH: low WIDTH bits of the product.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 start = valid_i && alu_ctrl_i==4'b0011 && state==IDLE; any other code SHALL leave the block in IDLE with stall_o=0.
REQ-013 On start in cycle 0: latch src1_i and src2_i, clear accumulator and counter, enter RUN at the next edge.
REQ-014 stall_o SHALL be combinational: 1 when start is true, or when state==RUN; otherwise 0.
REQ-015 Each RUN cycle: if multiplier LSB is 1, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter += 1; all arithmetic modulo 2^WIDTH.
REQ-016 After WIDTH RUN cycles (cycles 1..32 for WIDTH=32): enter DONE; result_o <= acc.
REQ-017 DONE lasts exactly one cycle (cycle 33): done_o=1, stall_o=0. The FSM then returns to IDLE.
REQ-018 start SHALL be ignored in DONE, so the same instruction is not re-issued.
REQ-019 The signed and unsigned low-half products are identical; no sign handling SHALL exist.
REQ-020 result_o SHALL hold its value until the next DONE or a reset.
REQ-021 flush_i in any state SHALL force IDLE at the next edge, with priority over start. done_o SHALL not pulse, and result_o SHALL be unchanged.

Reset
REQ-022 rst_i low SHALL immediately force state=IDLE, result_o=0, done_o=0, accumulator=0, counter=0, with stall_o=0 for the duration of reset.
REQ-023 Reset during RUN SHALL discard the operation; no done_o follows the release of reset.

Configuration
REQ-024 Macro MUL_EARLY_TERM_EN, when defined: in RUN, if the multiplier register is 0 at the start of a cycle, the FSM SHALL skip accumulation and enter DONE at the next edge.
REQ-025 When MUL_EARLY_TERM_EN is undefined: always exactly WIDTH RUN cycles; result_o SHALL be identical in both builds.

Structure
REQ-026 Package ex_mul_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE), ALU_CTRL_MUL=4'b0011 and the default WIDTH.
REQ-027 No sub-module; the datapath and FSM SHALL be in ex_mul_unit (counter width clog2(WIDTH)+1).

Verification
REQ-028 Case 1: src1=7, src2=6, mul code in cycle 0 -> stall_o high cycles 0..32, done_o=1 and result_o=42 in cycle 33.
REQ-029 Case 2: src1=32'hFFFFFFFD (-3), src2=5 -> result_o=32'hFFFFFFF1. Case 3: both operands 32'hFFFFFFFF -> result_o=32'h00000001.
REQ-030 Case 4: flush_i=1 in cycle 10 of a multiply with src1=7, src2=6, after a prior result of 42 -> IDLE and stall_o=0 in cycle 11, no done_o, result_o stays 42.
REQ-031 Case 5: valid_i=1, alu_ctrl_i=4'b0010 -> stall_o=0, done_o=0 and the FSM stays IDLE. Case 6: rst_i low in cycle 5 of RUN -> immediate zero outputs, no done_o after release.
REQ-032 Case 7, MUL_EARLY_TERM_EN defined: src2=0 -> done_o in cycle 2, result_o=0; src2=1, src1=9 -> done_o in cycle 3, result_o=9.
